// File: rtl/regfile_debug_dumper.sv
// Walks FIRST_REG..LAST_REG through the register file debug port and streams each word MSB byte first.
// First byte 3 cycles after start; each byte held on out_data/out_valid while out_ready is low.
module regfile_debug_dumper #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  debug_address,
  output logic        debug_clock,
  input  logic [31:0] debug_data,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  generate
    if (FIRST_REG < 0 || FIRST_REG > 31 || LAST_REG > 31 || FIRST_REG > LAST_REG) begin : g_bad_cfg
      $error("regfile_debug_dumper: need 0 <= FIRST_REG <= LAST_REG <= 31");
    end
  endgenerate

  localparam logic [4:0] FIRST = 5'(FIRST_REG);
  localparam logic [4:0] LAST  = 5'(LAST_REG);

  typedef enum logic [2:0] {
    IDLE,
    SET_ADDR,
    STROBE,
    CAPTURE,
    SEND,
    DONE
  } state_t;

  state_t      state;
  logic [4:0]  reg_idx;
  logic [1:0]  byte_idx;
  // Top byte goes straight to out_data at capture, so only the remaining 24 bits are kept.
  logic [23:0] pending;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      debug_address <= FIRST;
      debug_clock   <= 1'b0;
      out_data      <= 8'h00;
      out_valid     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      reg_idx       <= FIRST;
      byte_idx      <= 2'd0;
      pending       <= 24'h0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state         <= SET_ADDR;
            busy          <= 1'b1;
            debug_address <= FIRST;
            reg_idx       <= FIRST;
          end
        end
        SET_ADDR: begin
          debug_clock <= 1'b1;
          state       <= STROBE;
        end
        STROBE: begin
          debug_clock <= 1'b0;
          state       <= CAPTURE;
        end
        CAPTURE: begin
          out_data  <= debug_data[31:24];
          pending   <= debug_data[23:0];
          out_valid <= 1'b1;
          byte_idx  <= 2'd0;
          state     <= SEND;
        end
        SEND: begin
          if (out_valid && out_ready) begin
            if (byte_idx != 2'd3) begin
              out_data <= pending[23:16];
              pending  <= {pending[15:0], 8'h00};
              byte_idx <= byte_idx + 2'd1;
            end else begin
              out_valid <= 1'b0;
              // Compare before incrementing so index 31 never wraps.
              if (reg_idx == LAST) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                reg_idx       <= reg_idx + 5'd1;
                debug_address <= reg_idx + 5'd1;
                state         <= SET_ADDR;
              end
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_debug_dumper.sv
// Scoreboarded bench: a byte-stream model built from a register array, checked by monitor processes.
module tb_regfile_debug_dumper;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic [4:0]  debug_address;
  logic        debug_clock;
  logic [31:0] debug_data;
  logic [7:0]  out_data;
  logic        out_valid, busy, done;

  logic        start5 = 1'b0;
  logic        ready5 = 1'b1;
  logic [4:0]  dbg_addr5;
  logic        dbg_clk5;
  logic [31:0] dbg_data5;
  logic [7:0]  out_data5;
  logic        out_valid5, busy5, done5;

  logic [31:0] mem [32];
  logic [7:0]  exp_q[$];
  logic [7:0]  exp5_q[$];

  int checks = 0, errors = 0;
  int xfer_cnt = 0, done_cnt = 0, bp_checks = 0;
  int xfer5 = 0, rises5 = 0;
  bit rand_ready = 1'b0, bp_req = 1'b0;

  regfile_debug_dumper dut (
    .clock(clock), .reset(reset), .start(start),
    .debug_address(debug_address), .debug_clock(debug_clock), .debug_data(debug_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  regfile_debug_dumper #(.FIRST_REG(5), .LAST_REG(5)) dut5 (
    .clock(clock), .reset(reset), .start(start5),
    .debug_address(dbg_addr5), .debug_clock(dbg_clk5), .debug_data(dbg_data5),
    .out_data(out_data5), .out_valid(out_valid5), .out_ready(ready5),
    .busy(busy5), .done(done5)
  );

  // Register file debug read ports: data latched on the strobe's rising edge.
  always @(posedge debug_clock) debug_data <= mem[debug_address];
  always @(posedge dbg_clk5)    dbg_data5  <= mem[dbg_addr5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic push_dump(input int first, input int last);
    for (int r = first; r <= last; r++)
      for (int b = 3; b >= 0; b--)
        exp_q.push_back(8'(mem[r] >> (8 * b)));
  endtask

  task automatic pulse_start();
    @(posedge clock); #1; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
  endtask

  // Ready driver plus main-stream monitor in one process.
  initial begin : mon
    bit prev_done;
    bit stalled;
    int stall_left;
    prev_done = 1'b0; stalled = 1'b0; stall_left = 0;
    forever begin
      @(posedge clock); #1;
      if (stall_left == 0 && bp_req && !stalled && xfer_cnt == 29 && out_valid) begin
        stalled = 1'b1;
        stall_left = 5;
      end
      if (stall_left > 0) begin
        chk("bp_valid_held", out_valid, 1);
        chk("bp_data_held", out_data, 8'hAD);
        bp_checks++;
        stall_left--;
        out_ready = 1'b0;
      end else begin
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      @(negedge clock);
      if (!reset) begin
        exp_q.delete();
        xfer_cnt = 0;
        stalled = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_byte: got %0h, expected no byte", out_data);
          end else begin
            chk($sformatf("byte%0d", xfer_cnt), out_data, exp_q.pop_front());
          end
          xfer_cnt++;
        end
        if (done) begin
          chk("done_one_cycle", prev_done, 0);
          chk("done_after_last_byte", exp_q.size(), 0);
          if (!prev_done) done_cnt++;
          xfer_cnt = 0;
          stalled = 1'b0;
        end
        prev_done = done;
      end
    end
  end

  initial begin : mon5
    bit prev_clk5;
    prev_clk5 = 1'b0;
    forever begin
      @(negedge clock);
      if (out_valid5 && ready5) begin
        if (exp5_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut5_extra_byte: got %0h, expected no byte", out_data5);
        end else begin
          chk($sformatf("dut5_byte%0d", xfer5), out_data5, exp5_q.pop_front());
        end
        xfer5++;
      end
      if (dbg_clk5 && !prev_clk5) begin
        rises5++;
        chk("dut5_strobe_addr", dbg_addr5, 5);
      end
      prev_clk5 = dbg_clk5;
    end
  end

  task automatic run_dump(input int repulse_at, input bit time_it);
    int d0, cycles, first_v;
    bit pulsed;
    push_dump(0, 31);
    d0 = done_cnt; first_v = -1; pulsed = 1'b0;
    pulse_start();
    cycles = 0;
    chk("busy_after_start", busy, 1);
    while (!done && cycles < 3000) begin
      if (out_valid && first_v < 0) first_v = cycles;
      if (repulse_at >= 0 && !pulsed && xfer_cnt == repulse_at) begin
        start = 1'b1;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      cycles++;
    end
    start = 1'b0;
    chk("done_seen", done, 1);
    if (time_it) begin
      chk("first_valid_latency", first_v, 3);
      chk("done_latency", cycles, 224);
    end
    @(posedge clock); #1;
    chk("done_dropped", done, 0);
    chk("busy_dropped", busy, 0);
    @(posedge clock); #1;
    chk("done_count", done_cnt - d0, 1);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int d0, n;
    for (int i = 0; i < 32; i++) mem[i] = 32'(i);
    mem[29] = 32'h1C;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_debug_address", debug_address, 0);
    chk("rst_debug_clock", debug_clock, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dut5_address", dbg_addr5, 5);
    reset = 1'b1;
    repeat (2) @(posedge clock);

    // Reset contents, sink always ready; also checks latencies.
    rand_ready = 1'b0;
    run_dump(-1, 1'b1);

    // Patched register with random backpressure and a fixed stall on byte AD.
    mem[7] = 32'hDEADBEEF;
    rand_ready = 1'b1;
    bp_req = 1'b1;
    run_dump(-1, 1'b0);
    bp_req = 1'b0;
    chk("bp_stall_cycles", bp_checks, 5);

    // Second start during reg 3 must be ignored.
    run_dump(13, 1'b0);

    // Reset mid-dump during reg 10.
    push_dump(0, 31);
    d0 = done_cnt;
    pulse_start();
    n = 0;
    while (!(xfer_cnt == 41 && out_valid) && n < 3000) begin
      @(posedge clock); #1;
      n++;
    end
    chk("reached_reg10", xfer_cnt, 41);
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_debug_clock", debug_clock, 0);
    chk("midrst_debug_address", debug_address, 0);
    chk("midrst_done", done, 0);
    repeat (20) @(posedge clock);
    #1;
    chk("midrst_no_done", done_cnt - d0, 0);
    chk("midrst_busy_stays_low", busy, 0);
    run_dump(-1, 1'b0);

    // Single-register instance.
    mem[5] = 32'h12345678;
    exp5_q.push_back(8'h12); exp5_q.push_back(8'h34);
    exp5_q.push_back(8'h56); exp5_q.push_back(8'h78);
    rises5 = 0; xfer5 = 0;
    @(posedge clock); #1; start5 = 1'b1;
    @(posedge clock); #1; start5 = 1'b0;
    n = 0;
    while (!done5 && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    chk("dut5_done_latency", n, 7);
    @(posedge clock); #1;
    chk("dut5_done_dropped", done5, 0);
    chk("dut5_busy_dropped", busy5, 0);
    chk("dut5_byte_count", xfer5, 4);
    chk("dut5_strobe_count", rises5, 1);
    chk("dut5_queue_drained", exp5_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_debug_dumper.md
Name: regfile_debug_dumper

Overview:
- Other end of the register file's debug read port. It walks the register file through that port and reads back registers FIRST_REG..LAST_REG.
- Each 32-bit word is serialized as a byte stream with a valid/ready handshake, for the UART/host debug path.
- Runs on the core clock. It generates the register file's debug strobe itself, so the strobe must connect to the register file's debug clock input.

Parameters:
- FIRST_REG, 0, index of the first register dumped (0..31).
- LAST_REG, 31, index of the last register dumped (FIRST_REG..31).

Ports:
- clock  input  1  core clock; all state updates on posedge.
- reset  input  1  synchronous, active-low; reset==0 at a posedge resets the block.
- start  input  1  request a dump; sampled in IDLE only.
- debug_address  output  5  drives the register file debug read address.
- debug_clock  output  1  registered strobe; drives the register file debug clock (register file latches on its rising edge).
- debug_data  input  32  register file debug data out.
- out_data  output  8  current byte.
- out_valid  output  1  out_data valid.
- out_ready  input  1  sink accepts byte; a transfer occurs on a posedge with out_valid && out_ready.
- busy  output  1  high from the accepted start until the DONE state is left.
- done  output  1  one-cycle pulse after the last byte transfers.

Behaviour:
- Reset values: state IDLE, debug_address=FIRST_REG, debug_clock=0, out_data=0, out_valid=0, busy=0, done=0, reg index=FIRST_REG, byte index=0. Reset overrides all other inputs, including mid-dump: the partial dump is discarded and no done pulse is issued.
- States: IDLE, SET_ADDR, STROBE, CAPTURE, SEND, DONE. All outputs are registered.
- IDLE: start==1 at edge E0 -> SET_ADDR, busy<=1, debug_address<=FIRST_REG.
- SET_ADDR: -> STROBE, debug_clock<=1. The address has been stable for at least one cycle before the strobe rises.
- STROBE: -> CAPTURE, debug_clock<=0.
- CAPTURE: latch debug_data into the 32-bit shift word.
  - out_data<=word[31:24], out_valid<=1, byte index<=0, -> SEND.
  - The first out_valid is seen high in the cycle after edge E3, i.e. 3 edges after start is accepted.
- SEND: out_data and out_valid are held stable while out_ready==0, for an unbounded number of cycles.
- On a transfer with byte index<3: shift the word, out_data<=next byte (big-endian: bits 31:24, 23:16, 15:8, 7:0), byte index+1.
- On a transfer with byte index==3: out_valid<=0.
  - If reg index==LAST_REG -> DONE, done<=1.
  - Else reg index+1, debug_address<=reg index+1, -> SET_ADDR.
- The comparison against LAST_REG happens before the increment, so index 31 never wraps to 0.
- DONE: done<=0, busy<=0, -> IDLE. done is high for exactly one cycle; a new start is accepted in IDLE at the earliest on the following edge.
- start is ignored in every state except IDLE; it is never queued.
- Per-register overhead: 3 cycles (SET_ADDR, STROBE, CAPTURE) plus 4 transfer cycles minimum.
  - With out_ready tied high, a full 0..31 dump takes 32*7 cycles plus the DONE cycle.
- The block does not freeze the core: words reflect register contents at each strobe's rising edge.
- Elaboration check: FIRST_REG>LAST_REG, or either parameter >31, is a configuration error.

Test Plan:
- Register file at reset contents (reg i=i, reg29=0x1C), out_ready=1, pulse start -> 128 bytes.
  - First four bytes are 00 00 00 00, then 00 00 00 01.
  - Reg 29 bytes are 00 00 00 1C; reg 31 bytes are 00 00 00 1F.
  - done pulses once, 1 cycle, after the 128th transfer; busy then drops.
- Write reg 7=0xDEADBEEF via the normal port, dump -> bytes 28..31 of the stream are DE AD BE EF.
- Backpressure: out_ready=0 for 5 cycles while the byte AD of reg 7 is presented -> out_data stays 0xAD and out_valid stays 1 for all 5 cycles; the stream continues with BE EF with no byte lost or duplicated.
- start pulsed again during the reg 3 transfer -> ignored; exactly 128 bytes and one done pulse.
- reset=0 for one edge during the reg 10 SEND state -> next cycle out_valid=0, busy=0, debug_clock=0, debug_address=0.
  - A new start then restarts the stream from reg 0 byte 00.
- FIRST_REG=LAST_REG=5, reg 5=0x12345678 -> exactly 4 bytes 12 34 56 78.
  - Exactly one debug_clock rising edge with debug_address=5.
  - done follows the 4th transfer.
